// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package modexp_pkg;

  localparam int DEF_WIDTH = 64;

  // A modulus at or above 2^ILLEGAL_N_SHIFT could overflow z*z inside the step unit.
  localparam int ILLEGAL_N_SHIFT = DEF_WIDTH / 2;

  function automatic int illegal_n_shift(input int width);
    return width / 2;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREP    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/modexp_ctrl_msb_index.sv
// Priority encoder: index of the most significant set bit, plus an all-zero flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_vec (WIDTH) in; o_idx ($clog2(WIDTH)) out, 0 when i_vec==0; o_zero out.
module msb_index
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IW-1:0]    o_idx,
  output logic             o_zero
);

  // Ascending scan: the last set bit seen wins, which is the MSB.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external step unit: result = x^e mod n.
// Latency: 1 + nbits*(STEP_LAT+1) + 1 cycles; 2 cycles for e==0 or an illegal modulus.
// Backpressure: start is accepted only in IDLE; start while busy (including the done cycle) is dropped.
// Ports: clk, rst_n (async, active low), start/x_in/e_in/n_in host request, busy/done/err/result host
//   status, step_z/step_e/step_x/step_n to the step unit, step_zz from the step unit.
// Optional: MODEXP_CYCLE_CNT_EN adds cyc_cnt[31:0], the saturating busy-cycle count of the last run.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] e_in,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] step_z,
  output logic             step_e,
  output logic [WIDTH-1:0] step_x,
  output logic [WIDTH-1:0] step_n,
  input  logic [WIDTH-1:0] step_zz
`ifdef MODEXP_CYCLE_CNT_EN
  ,
  output logic [31:0]      cyc_cnt
`endif
);

  localparam int IW   = $clog2(WIDTH);
  localparam int HALF = illegal_n_shift(WIDTH);
  localparam int LATW = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_step_x;
  logic [WIDTH-1:0] r_step_n;
  logic             r_err;
  logic [IW-1:0]    r_idx;
  logic [LATW-1:0]  r_wcnt;
  logic [IW-1:0]    w_msb;
  logic             w_e_zero;
  logic             w_n_bad;
  logic             w_lat_done;
  logic             w_run;

  msb_index #(.WIDTH(WIDTH), .IW(IW)) u_msb (
    .i_vec  (r_e),
    .o_idx  (w_msb),
    .o_zero (w_e_zero)
  );

  assign w_n_bad    = (r_n == '0) || ((r_n >> HALF) != '0);
  // r_wcnt counts edges since ISSUE; step_zz is valid once STEP_LAT edges have passed.
  assign w_lat_done = (r_wcnt == LATW'(STEP_LAT - 1));
  assign w_run      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:           if (start) w_next = S_PREP;
      S_PREP:           w_next = (w_n_bad || w_e_zero) ? S_DONE : S_ISSUE;
      S_ISSUE, S_WAIT:  w_next = w_lat_done ? S_CAPTURE : S_WAIT;
      S_CAPTURE:        w_next = (r_idx == '0) ? S_DONE : S_ISSUE;
      S_DONE:           w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e      <= '0;
      r_n      <= '0;
      r_z      <= '0;
      r_result <= '0;
      r_step_x <= '0;
      r_step_n <= '0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_wcnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_e      <= e_in;
            r_n      <= n_in;
            r_err    <= 1'b0;
            r_result <= '0;
          end
        end
        S_PREP: begin
          r_wcnt <= '0;
          if (w_n_bad) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            // x_in is still held by the host in this cycle.
            r_step_x <= x_in % r_n;
            r_step_n <= r_n;
            r_idx    <= w_msb;
            r_z      <= WIDTH'(1);
            if (w_e_zero) r_result <= WIDTH'(r_n != WIDTH'(1));
          end
        end
        S_ISSUE, S_WAIT: begin
          r_wcnt <= w_lat_done ? '0 : r_wcnt + 1'b1;
        end
        S_CAPTURE: begin
          r_z <= step_zz;
          if (r_idx == '0) r_result <= step_zz;
          else             r_idx    <= r_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign result = r_result;
  assign step_z = r_z;
  assign step_e = w_run & r_e[r_idx];
  assign step_x = r_step_x;
  assign step_n = r_step_n;

`ifdef MODEXP_CYCLE_CNT_EN
  logic [31:0] r_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cyc <= '0;
    else if (start && !busy)         r_cyc <= '0;
    else if (busy && (r_cyc != '1))  r_cyc <= r_cyc + 32'd1;
  end

  assign cyc_cnt = r_cyc;
`endif

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench: two sequencers (STEP_LAT 1 and 3) share one host stimulus; each has its own step-unit model.
// A behavioural reference predicts busy/done timing, result and err per instance.
module tb_modexp_ctrl;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  x_in = '0, e_in = '0, n_in = '0;
  logic [1:0]    busy, done, err, step_e;
  logic [W-1:0]  result [2];
  logic [W-1:0]  step_z [2];
  logic [W-1:0]  step_x [2];
  logic [W-1:0]  step_n [2];
  logic [W-1:0]  step_zz [2];
  logic [31:0]   cyc_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic n_illegal(input logic [W-1:0] n);
    return (n == 0) || (n >= 64'h1_0000_0000);
  endfunction

  // Right-to-left exponentiation: a different algorithm from the DUT's scan order.
  function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [W-1:0] r, b, k;
    r = 1 % n;
    b = x % n;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * b) % n;
      b = (b * b) % n;
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [W-1:0] e, input logic bad, input int l);
    int nb = 0;
    for (int i = 0; i < W; i++) if (e[i]) nb = i + 1;
    if (bad || nb == 0) return 2;
    return 2 + nb * (l + 1);
  endfunction

  function automatic logic [W-1:0] step_fn(input logic [W-1:0] z, input logic e,
                                           input logic [W-1:0] x, input logic [W-1:0] n);
    logic [W-1:0] zz;
    if (n == 0) return '0;
    zz = (z * z) % n;
    if (e) zz = (zz * x) % n;
    return zz;
  endfunction

  task automatic check(input string nm, input int g, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, g, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [W-1:0] pipe [L];

    modexp_ctrl #(.WIDTH(W), .STEP_LAT(L)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .x_in    (x_in),
      .e_in    (e_in),
      .n_in    (n_in),
      .busy    (busy[g]),
      .done    (done[g]),
      .err     (err[g]),
      .result  (result[g]),
      .step_z  (step_z[g]),
      .step_e  (step_e[g]),
      .step_x  (step_x[g]),
      .step_n  (step_n[g]),
`ifdef MODEXP_CYCLE_CNT_EN
      .cyc_cnt (cyc_cnt[g]),
`endif
      .step_zz (step_zz[g])
    );

`ifndef MODEXP_CYCLE_CNT_EN
    assign cyc_cnt[g] = '0;
`endif

    // Behavioural step unit with L registered stages.
    always @(posedge clk) begin
      pipe[0] <= step_fn(step_z[g], step_e[g], step_x[g], step_n[g]);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign step_zz[g] = pipe[L-1];
  end

  // Reference model: remaining busy cycles and expected outcome per instance.
  int           m_rem [2] = '{0, 0};
  int           m_lat [2] = '{0, 0};
  logic [W-1:0] m_res [2];
  logic [W-1:0] m_x [2];
  logic [W-1:0] m_n [2];
  logic         m_err [2];
  logic         m_chk [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        m_rem[g] <= 0;
      end else if (m_rem[g] == 0) begin
        if (start) begin
          m_err[g] <= n_illegal(n_in);
          m_x[g]   <= x_in;
          m_n[g]   <= n_in;
          m_res[g] <= n_illegal(n_in) ? '0 : modpow(x_in, e_in, n_in);
          m_rem[g] <= model_lat(e_in, n_illegal(n_in), lat_of(g));
          m_lat[g] <= model_lat(e_in, n_illegal(n_in), lat_of(g));
        end
      end else begin
        m_rem[g] <= m_rem[g] - 1;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        m_chk[g] <= 1'b0;
      end else begin
        check("busy", g, W'(busy[g]), W'(m_rem[g] != 0));
        check("done", g, W'(done[g]), W'(m_rem[g] == 1));
        if (m_rem[g] == 1) begin
          check("result", g, result[g], m_res[g]);
          check("err", g, W'(err[g]), W'(m_err[g]));
          m_chk[g] <= 1'b1;
        end
        if (m_rem[g] > 0 && m_rem[g] < m_lat[g] && !m_err[g]) begin
          check("step_n", g, step_n[g], m_n[g]);
          check("step_x", g, step_x[g], m_x[g] % m_n[g]);
        end
`ifdef MODEXP_CYCLE_CNT_EN
        if (m_rem[g] == 0 && m_chk[g]) begin
          check("cyc_cnt", g, W'(cyc_cnt[g]), W'(m_lat[g]));
          m_chk[g] <= 1'b0;
        end
`endif
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] n);
    @(negedge clk);
    x_in = x; e_in = e; n_in = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy != 2'b00 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy != 2'b00) begin
      n_bad++;
      $display("FAIL timeout busy=%b want=00", busy);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      check({nm, "_flags"}, g, W'({busy[g], done[g], err[g], step_e[g]}), '0);
      check({nm, "_result"}, g, result[g], '0);
      check({nm, "_step"}, g, step_z[g] | step_x[g] | step_n[g], '0);
    end
  endtask

  task automatic check_res(input string nm, input logic [W-1:0] want, input logic want_err);
    for (int g = 0; g < 2; g++) begin
      check(nm, g, result[g], want);
      check({nm, "_err"}, g, W'(err[g]), W'(want_err));
    end
  endtask

  function automatic logic [W-1:0] rand_n();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return 64'd1;
      2:       return 64'h1_0000_0000 + W'($urandom);
      3:       return 64'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Pin the model itself to hand-computed values.
    check("pin_pow357", 0, modpow(64'd3, 64'd5, 64'd7), 64'd5);
    check("pin_pow2_10", 0, modpow(64'd2, 64'd10, 64'd1000), 64'd24);
    check("pin_pow_e0", 0, modpow(64'd1234, 64'd0, 64'd1000), 64'd1);
    check("pin_pow_n1", 0, modpow(64'd5, 64'd3, 64'd1), 64'd0);
    check("pin_lat1", 0, W'(model_lat(64'd5, 1'b0, 1)), 64'd8);
    check("pin_lat3", 1, W'(model_lat(64'd5, 1'b0, 3)), 64'd14);
    check("pin_lat_e0", 0, W'(model_lat(64'd0, 1'b0, 1)), 64'd2);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    launch(64'd3, 64'd5, 64'd7);              wait_idle(); check_res("r357", 64'd5, 1'b0);
`ifdef MODEXP_CYCLE_CNT_EN
    check("cyc_357", 0, W'(cyc_cnt[0]), 64'd8);
    check("cyc_357", 1, W'(cyc_cnt[1]), 64'd14);
`endif
    launch(64'd2, 64'd10, 64'd1000);          wait_idle(); check_res("r2_10", 64'd24, 1'b0);
    launch(64'd1234, 64'd0, 64'd1000);        wait_idle(); check_res("r_e0", 64'd1, 1'b0);
    launch(64'd5, 64'd3, 64'd1);              wait_idle(); check_res("r_n1", 64'd0, 1'b0);
    launch(64'd5, 64'd3, 64'd0);              wait_idle(); check_res("r_n0", 64'd0, 1'b1);
    launch(64'd5, 64'd3, 64'h1_0000_0000);    wait_idle(); check_res("r_nbig", 64'd0, 1'b1);

    // A second start mid-run must be ignored by both instances.
    launch(64'd3, 64'd5, 64'd7);
    repeat (2) @(negedge clk);
    launch(64'd2, 64'd10, 64'd1000);
    wait_idle(); check_res("r_ignore", 64'd5, 1'b0);

    // Reset in the middle of a run, then a clean run.
    launch(64'd2, 64'd10, 64'd1000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    launch(64'd2, 64'd10, 64'd1000);          wait_idle(); check_res("r_afterrst", 64'd24, 1'b0);

    // Randomised runs, sometimes with a stray start at a random offset.
    for (int i = 0; i < 40; i++) begin
      launch({$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 63), rand_n());
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        launch(W'($urandom), W'($urandom_range(0, 255)), W'($urandom_range(0, 5000)));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
